// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// Module   : serial_subtractor
// Brief    : Bit-serial unsigned subtractor. Computes a - b LSB-first, one bit
//            per clock, using one full-subtractor cell and a borrow flop.
//            Provides a registered difference, a final borrow flag and a
//            one-cycle done pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Counter needs at least one bit so WIDTH=1 still has a legal vector.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_bin;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell working on the current LSB of the operand shifters.
  assign w_ai   = r_a[0];
  assign w_bi   = r_b[0];
  assign w_d    = w_ai ^ w_bi ^ r_bin;
  assign w_bout = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bin);
  assign w_last = (r_cnt == C_LAST);

  // The new difference bit enters from the MSB side; a 1-bit result has
  // nothing to shift, so that case is split out.
  if (WIDTH == 1) begin : g_res_w1
    assign w_res_next = w_d;
  end else begin : g_res_wn
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // busy/done are flopped from the next state so they are true registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (w_state_next != S_IDLE);
      done <= (w_state_next == S_DONE);
    end
  end

  // Datapath: load operands on accept, shift one bit per RUN cycle, publish
  // the result only on the last bit so partial sums never reach the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_bin  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_res <= '0;
            r_cnt <= '0;
            r_bin <= 1'b0;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_bin <= w_bout;
          if (w_last) begin
            diff   <= w_res_next;
            borrow <= w_bout;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_subtractor
// Brief    : Directed self-checking bench for serial_subtractor (WIDTH=8 and
//            WIDTH=1 instances sharing clock and reset).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borrow8;
  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borrow1;

  int total;
  int bad;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (borrow8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .a      (a1),
    .b      (b1),
    .busy   (busy1),
    .done   (done1),
    .diff   (diff1),
    .borrow (borrow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation. Sample point i is the negedge between E(i-1) and
  // E(i) after accept edge E0: done expected at i=9, busy high for i=1..9.
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb);
    int done_at;
    int nbusy;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    done_at = 0;
    nbusy   = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (done8 && done_at == 0) done_at = i;
    end
    check({tag, "_diff"},   32'(diff8),   32'(ed));
    check({tag, "_borrow"}, 32'(borrow8), 32'(eb));
    check({tag, "_donecyc"}, 32'(done_at), 32'd9);
    check({tag, "_busycyc"}, 32'(nbusy),   32'd9);
  endtask

  // One 1-bit operation: done expected at i=2, busy for i=1..2.
  task automatic op1(input string tag, input logic av, input logic bv,
                     input logic ed, input logic eb);
    int done_at;
    int nbusy;
    @(negedge clk);
    a1 = av; b1 = bv; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    done_at = 0;
    nbusy   = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (busy1) nbusy++;
      if (done1 && done_at == 0) done_at = i;
    end
    check({tag, "_diff"},    32'(diff1),   32'(ed));
    check({tag, "_borrow"},  32'(borrow1), 32'(eb));
    check({tag, "_donecyc"}, 32'(done_at), 32'd2);
    check({tag, "_busycyc"}, 32'(nbusy),   32'd2);
  endtask

  initial begin
    int ndone;
    int nbusy;
    total = 0; bad = 0;
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(busy8),   32'd0);
    check("rst_done",   32'(done8),   32'd0);
    check("rst_diff",   32'(diff8),   32'd0);
    check("rst_borrow", 32'(borrow8), 32'd0);
    rst = 1'b0;

    // Main function and edge operands.
    op8("basic", 8'h5A, 8'h25, 8'h35, 1'b0);
    op8("under", 8'h10, 8'h20, 8'hF0, 1'b1);
    op8("z_z",   8'h00, 8'h00, 8'h00, 1'b0);
    op8("f_f",   8'hFF, 8'hFF, 8'h00, 1'b0);
    op8("z_1",   8'h00, 8'h01, 8'hFF, 1'b1);
    op8("f_z",   8'hFF, 8'h00, 8'hFF, 1'b0);

    // Start while busy: extra starts in RUN (edge E3) and DONE (edge E9)
    // must be dropped.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    a8 = 8'h00; b8 = 8'hFF;
    ndone = 0; nbusy = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (done8) ndone++;
      start8 = (i == 3 || i == 9);
    end
    start8 = 1'b0;
    check("busy_start_diff",   32'(diff8),   32'h7F);
    check("busy_start_borrow", 32'(borrow8), 32'd0);
    check("busy_start_ndone",  32'(ndone),   32'd1);
    check("busy_start_nbusy",  32'(nbusy),   32'd9);

    // Asynchronous reset while bit 4 is being processed.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy",   32'(busy8),   32'd0);
    check("midrst_done",   32'(done8),   32'd0);
    check("midrst_diff",   32'(diff8),   32'd0);
    check("midrst_borrow", 32'(borrow8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    op8("after_rst", 8'h33, 8'h11, 8'h22, 1'b0);

    // WIDTH=1 instance, all four input combinations.
    op1("w1_00", 1'b0, 1'b0, 1'b0, 1'b0);
    op1("w1_10", 1'b1, 1'b0, 1'b1, 1'b0);
    op1("w1_01", 1'b0, 1'b1, 1'b1, 1'b1);
    op1("w1_11", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
